ifetch_unit: RTL and testbench

Instruction fetch front end; the initiator side of the instruction memory interface. Owns the PC and drives the fetch address each cycle. Captures the returned instruction word and access-fault status, and queues them as fetch packets in a small FIFO. Packets go to decode over a valid/ready handshake. Redirects from execute/trap logic flush the queue and restart fetch.

---
 rtl/ifetch_unit.sv | 169 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC, imem initiator, fetch packet queue
module ifetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {ST_FETCH = 1'b0, ST_HALT = 1'b1} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } pkt_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    pkt_t          fifo_q [FIFO_DEPTH];
    pkt_t          fifo_d [FIFO_DEPTH];

    logic fetch_en;
    logic enq;
    logic deq;
    logic misaligned;
    logic fault;
    pkt_t push_pkt;
    pkt_t head_pkt;

    assign imem_addr = pc_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic: a faulting enqueue halts, only a redirect resumes
    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = ST_FETCH;
        end else if (enq && fault) begin
            state_d = ST_HALT;
        end
    end

    // FSM outputs
    always_comb begin
        fetch_en = 1'b0;
        if (state_q == ST_FETCH) begin
            fetch_en = 1'b1;
        end
    end

    // Misalignment takes precedence: the memory response is ignored entirely.
    always_comb begin
        misaligned = (pc_q[1:0] != 2'b00);
        fault      = misaligned || imem_exc_en;
        enq        = fetch_en && (count_q < CW'(FIFO_DEPTH)) && !redirect_en;
        out_valid  = (count_q != '0) && !redirect_en;
        deq        = out_valid && out_ready;

        push_pkt.pc = pc_q;
        if (misaligned) begin
            push_pkt.instr    = NOP;
            push_pkt.exc_en   = 1'b1;
            push_pkt.exc_code = 4'd0;
            push_pkt.exc_val  = pc_q;
        end else if (imem_exc_en) begin
            push_pkt.instr    = NOP;
            push_pkt.exc_en   = 1'b1;
            push_pkt.exc_code = imem_exc_code;
            push_pkt.exc_val  = imem_exc_val;
        end else begin
            push_pkt.instr    = imem_instr;
            push_pkt.exc_en   = 1'b0;
            push_pkt.exc_code = 4'd0;
            push_pkt.exc_val  = 64'd0;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        if (redirect_en) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) begin
                fifo_d[wr_ptr_q] = push_pkt;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                if (!fault) begin
                    pc_d = pc_q + 64'd4;
                end
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // queue storage needs no reset; the outputs are masked while empty
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_comb begin
        head_pkt = '0;
        if (count_q != '0) begin
            head_pkt = fifo_q[rd_ptr_q];
        end
        out_pc       = head_pkt.pc;
        out_instr    = head_pkt.instr;
        out_exc_en   = head_pkt.exc_en;
        out_exc_code = head_pkt.exc_code;
        out_exc_val  = head_pkt.exc_val;
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized self-checking bench for ifetch_unit against a queue model
module tb_ifetch_unit;
    localparam logic [63:0] RST_PC   = 64'h0;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] MEM_TOP  = 64'h4000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_exc_en(imem_exc_en),
        .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_exc_en(out_exc_en),
        .out_exc_code(out_exc_code), .out_exc_val(out_exc_val)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4096];

    // memory: words below MEM_TOP are readable, anything above faults with cause 1
    always_comb begin
        if (imem_addr < MEM_TOP) begin
            imem_instr    = mem[imem_addr[13:2]];
            imem_exc_en   = 1'b0;
            imem_exc_code = 4'd0;
            imem_exc_val  = 64'd0;
        end else begin
            imem_instr    = ~imem_addr[31:0];
            imem_exc_en   = 1'b1;
            imem_exc_code = 4'd1;
            imem_exc_val  = imem_addr;
        end
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  code;
        logic [63:0] val;
    } pkt_t;

    pkt_t        q[$];
    logic [63:0] m_pc;
    bit          m_halted;
    bit          just_reset;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic pkt_t fetch_model(input logic [63:0] a);
        pkt_t p;
        p.pc = a;
        if (a[1:0] != 2'b00) begin
            p.instr = 32'h13; p.exc = 1'b1; p.code = 4'd0; p.val = a;
        end else if (a >= MEM_TOP) begin
            p.instr = 32'h13; p.exc = 1'b1; p.code = 4'd1; p.val = a;
        end else begin
            p.instr = mem[a[13:2]]; p.exc = 1'b0; p.code = 4'd0; p.val = 64'd0;
        end
        return p;
    endfunction

    // one clock cycle: drive, check combinational view, advance model, cross the edge
    task automatic step(input bit r, input bit redir, input logic [63:0] rpc,
                        input bit rdy, input bit do_check);
        pkt_t p;
        bit   had;
        @(negedge clk);
        rst = r; redirect_en = redir; redirect_pc = rpc; out_ready = rdy;
        #1;
        if (do_check) begin
            check("imem_addr", imem_addr, m_pc);
            check("out_valid", 64'(out_valid), 64'((q.size() != 0) && !redir));
            if (q.size() != 0) begin
                check("out_pc", out_pc, q[0].pc);
                check("out_instr", 64'(out_instr), 64'(q[0].instr));
                check("out_exc_en", 64'(out_exc_en), 64'(q[0].exc));
                check("out_exc_code", 64'(out_exc_code), 64'(q[0].code));
                check("out_exc_val", out_exc_val, q[0].val);
            end
            if (just_reset) begin
                check("rst_out_pc", out_pc, 64'd0);
                check("rst_out_instr", 64'(out_instr), 64'd0);
                check("rst_out_exc", {out_exc_val[62:0], out_exc_en} | 64'(out_exc_code), 64'd0);
            end
        end
        if (r) begin
            q.delete(); m_pc = RST_PC; m_halted = 0; just_reset = 1;
        end else begin
            just_reset = 0;
            if (redir) begin
                q.delete(); m_pc = rpc; m_halted = 0;
            end else begin
                had = (q.size() < DEPTH) && !m_halted;
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (had) begin
                    p = fetch_model(m_pc);
                    q.push_back(p);
                    if (p.exc) m_halted = 1;
                    else m_pc = m_pc + 64'd4;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [63:0] rp;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        rst = 1; redirect_en = 0; redirect_pc = 0; out_ready = 1;
        m_pc = RST_PC; m_halted = 0; just_reset = 0;
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        // in-order streaming
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
        // backpressure until full, then drain
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        // run off the end of memory into an access fault, then recover
        step(0, 1, 64'h3FF0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
        step(0, 1, 64'h100, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        // misaligned redirect
        step(0, 1, 64'h102, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        // full queue flushed by a redirect while decode is ready
        step(0, 1, 64'h200, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 64'h300, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        // reset while halted with one queued packet
        step(0, 1, 64'h106, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: rp = {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
                1: rp = {50'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
                2: rp = MEM_TOP - 64'(4 * $urandom_range(0, 4));
                default: rp = {$urandom, $urandom};
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), rp,
                 ($urandom_range(0, 3) != 0), 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
